// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, FSM state type and keep-mask helper
// for the synthetic frame generator.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;
    localparam int PAYLOAD_OFS = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;  // 42
    // Bytes that are not plain offset pattern: all headers plus the 32-bit sequence number.
    localparam int HDR_BYTES   = PAYLOAD_OFS + 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } gen_state_t;

    // Keep mask for the final beat; len is the frame length modulo 8.
    function automatic logic [7:0] tkeep_from_len(input logic [2:0] len);
        if (len == 3'd0) begin
            return 8'hFF;
        end
        return (8'h01 << len) - 8'h01;
    endfunction

endpackage

// File: rtl/ipv4_hdr_csum.sv
// Combinational IPv4 header checksum for the fixed header this generator
// emits (version/IHL 0x45, DF set, TTL 0x40, protocol UDP, no options).
module ipv4_hdr_csum
    import eth_pkg::*;
(
    input  logic [15:0] total_len,
    input  logic [15:0] ip_id,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    output logic [15:0] csum
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Ones'-complement sum of the ten header words, checksum word counted as zero.
    always_comb begin
        sum   = 20'h04500 + 20'(total_len) + 20'(ip_id) + 20'h04000
              + 20'({8'h40, IP_PROTO_UDP})
              + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
              + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
        fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);
        csum  = ~fold2;
    end

endmodule

// File: rtl/udp_flood_gen.sv
// Synthetic Ethernet/IPv4/UDP frame generator driving a 64-bit AXI4-Stream
// MAC transmit input. Each frame carries a 32-bit sequence number (the value
// of frames_sent at frame start) so the receiver can detect loss/reordering.
// GAP_CYCLES must be at least 1.
module udp_flood_gen
    import eth_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514
) (
    input  logic        refclk_p,
    input  logic        reset,
    input  logic        enable,
    input  logic [10:0] frame_len,
    input  logic [31:0] frame_limit,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] frames_sent,
    output logic        busy
);

    localparam logic [10:0] MIN_LEN_V = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_V = 11'(MAX_LEN);
    localparam int          GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    gen_state_t       state;
    gen_state_t       state_next;
    logic [10:0]      len_q;
    logic [31:0]      seq_q;
    logic [15:0]      csum_q;
    logic [7:0]       beat_q;
    logic [GAP_W-1:0] gap_q;
    logic [31:0]      en_count;

    logic [10:0]      len_clamped;
    logic [15:0]      csum_w;
    logic [7:0]       last_idx;
    logic             last_beat;
    logic             handshake;
    logic             limit_reached;
    logic             gap_done;
    logic [15:0]      ip_total_len;
    logic [15:0]      udp_len;
    logic [HDR_BYTES*8-1:0] hdr;
    logic [7:0]       hdr_byte [64];
    logic [63:0]      lane_data;

    assign len_clamped   = (frame_len < MIN_LEN_V) ? MIN_LEN_V :
                           (frame_len > MAX_LEN_V) ? MAX_LEN_V : frame_len;
    assign limit_reached = (frame_limit != 32'd0) && (en_count == frame_limit);
    assign last_idx      = len_q[10:3] - {7'd0, (len_q[2:0] == 3'd0)};
    assign last_beat     = (beat_q == last_idx);
    assign handshake     = (state == ST_SEND) && m_axis_tready;
    assign gap_done      = (gap_q == GAP_W'(GAP_CYCLES - 1));
    assign ip_total_len  = {5'd0, len_q} - 16'(ETH_HDR_LEN);
    assign udp_len       = {5'd0, len_q} - 16'(PAYLOAD_OFS - UDP_HDR_LEN);

    // Header checksum is evaluated on the values about to be latched in LOAD.
    ipv4_hdr_csum u_csum (
        .total_len (16'(len_clamped) - 16'(ETH_HDR_LEN)),
        .ip_id     (frames_sent[15:0]),
        .src_ip    (src_ip),
        .dst_ip    (dst_ip),
        .csum      (csum_w)
    );

    // Network-order header image, byte 0 in the most significant position.
    assign hdr = {dst_mac, src_mac, ETHERTYPE_IPV4, 8'h45, 8'h00,
                  ip_total_len, seq_q[15:0], 16'h4000, 8'h40, IP_PROTO_UDP,
                  csum_q, src_ip, dst_ip, src_port, dst_port,
                  udp_len, 16'h0000, seq_q};

    // Split the header image into an offset-indexed byte table.
    always_comb begin
        for (int k = 0; k < 64; k++) begin
            hdr_byte[k] = 8'h00;
        end
        for (int k = 0; k < HDR_BYTES; k++) begin
            hdr_byte[k] = hdr[(HDR_BYTES-1-k)*8 +: 8];
        end
    end

    // Select each output lane's byte by its frame offset; bytes past len are zero.
    always_comb begin : lane_mux
        logic [10:0] ofs;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        lane_data = '0;
        ofs       = '0;
        for (int i = 0; i < 8; i++) begin
            ofs = {beat_q, 3'b000} + 11'(i);
            if (ofs < len_q) begin
                lane_data[8*i +: 8] = (ofs < 11'(HDR_BYTES)) ? hdr_byte[ofs[5:0]] : ofs[7:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge refclk_p) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; the GAP exit sees the already-incremented frame count.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable && !limit_reached) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: if (handshake && last_beat) state_next = ST_GAP;
            ST_GAP:  if (gap_done) state_next = (enable && !limit_reached) ? ST_LOAD : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame latches, beat/gap counters and frame statistics.
    always_ff @(posedge refclk_p) begin
        if (reset) begin
            len_q       <= '0;
            seq_q       <= '0;
            csum_q      <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            en_count    <= '0;
            frames_sent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!enable) en_count <= '0;
                end
                ST_LOAD: begin
                    len_q  <= len_clamped;
                    seq_q  <= frames_sent;
                    csum_q <= csum_w;
                    beat_q <= '0;
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (last_beat) begin
                            frames_sent <= frames_sent + 32'd1;
                            en_count    <= en_count + 32'd1;
                            gap_q       <= '0;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    gap_q <= gap_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stream outputs are pure functions of registered state, so they hold while stalled.
    assign m_axis_tvalid = (state == ST_SEND);
    assign m_axis_tdata  = m_axis_tvalid ? lane_data : 64'd0;
    assign m_axis_tkeep  = !m_axis_tvalid ? 8'h00 :
                           last_beat ? tkeep_from_len(len_q[2:0]) : 8'hFF;
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign m_axis_tuser  = 1'b0;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_udp_flood_gen.sv
// Self-checking bench for udp_flood_gen: a byte-level frame model built from
// the frame layout rules is compared against every beat, plus literal
// expectations for hand-computed fields.
module tb_udp_flood_gen;

    localparam int GAP_CYCLES = 2;
    localparam int MIN_LEN    = 60;
    localparam int MAX_LEN    = 1514;

    logic        refclk_p = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic [10:0] frame_len   = 11'd60;
    logic [31:0] frame_limit = 32'd1;
    logic [47:0] dst_mac  = 48'h0200_0000_0002;
    logic [47:0] src_mac  = 48'h0200_0000_0001;
    logic [31:0] src_ip   = 32'h0A00_0001;
    logic [31:0] dst_ip   = 32'h0A00_0002;
    logic [15:0] src_port = 16'd1234;
    logic [15:0] dst_port = 16'd5678;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic [31:0] frames_sent;
    logic        busy;

    udp_flood_gen #(
        .GAP_CYCLES (GAP_CYCLES),
        .MIN_LEN    (MIN_LEN),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .refclk_p      (refclk_p),
        .reset         (reset),
        .enable        (enable),
        .frame_len     (frame_len),
        .frame_limit   (frame_limit),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .src_ip        (src_ip),
        .dst_ip        (dst_ip),
        .src_port      (src_port),
        .dst_port      (dst_port),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frames_sent   (frames_sent),
        .busy          (busy)
    );

    always #5 refclk_p = ~refclk_p;

    int          checks   = 0;
    int          failures = 0;
    bit          rand_ready = 1'b0;

    // Model state
    logic [7:0]  exp_frame [0:2047];
    logic [7:0]  cap       [0:2047];
    logic [7:0]  last_cap  [0:2047];
    int          model_len = 0;
    logic [31:0] model_sent = 0;
    bit          in_frame = 1'b0;
    int          cur_beat = 0;
    int          done_cnt = 0;
    int          cycle = 0;
    int          last_end_cycle = -1000;
    int          last_beats = 0;
    logic [7:0]  last_keep = 0;
    int          gap_q [$];
    bit          have_prev = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l < MIN_LEN) return MIN_LEN;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    task automatic put_be(input int ofs, input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) exp_frame[ofs+i] = v[8*(n-1-i) +: 8];
    endtask

    // Build the whole expected frame from the layout rules.
    task automatic build_frame(input int len, input logic [31:0] seq);
        int unsigned s;
        for (int o = 0; o < len; o++) exp_frame[o] = 8'(o);
        put_be(0,  64'(dst_mac), 6);
        put_be(6,  64'(src_mac), 6);
        put_be(12, 64'h0800, 2);
        put_be(14, 64'h4500, 2);
        put_be(16, 64'(len - 14), 2);
        put_be(18, 64'(seq[15:0]), 2);
        put_be(20, 64'h4000, 2);
        put_be(22, 64'h4011, 2);
        put_be(24, 64'h0, 2);
        put_be(26, 64'(src_ip), 4);
        put_be(30, 64'(dst_ip), 4);
        put_be(34, 64'(src_port), 2);
        put_be(36, 64'(dst_port), 2);
        put_be(38, 64'(len - 34), 2);
        put_be(40, 64'h0, 2);
        put_be(42, 64'(seq), 4);
        s = 0;
        for (int w = 0; w < 10; w++) s += {16'h0, exp_frame[14+2*w], exp_frame[15+2*w]};
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        put_be(24, 64'(~s[15:0]), 2);
    endtask

    // Ready driver: changes just after the rising edge.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge refclk_p);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: checks every cycle on the falling edge.
    initial begin
        logic [63:0] e_data;
        logic [7:0]  e_keep;
        logic        e_last;
        int          rem;
        forever begin
            @(negedge refclk_p);
            cycle++;
            if (reset) begin
                in_frame   = 1'b0;
                have_prev  = 1'b0;
                cur_beat   = 0;
                model_sent = 0;
            end else begin
                check("frames_sent", 64'(frames_sent), 64'(model_sent));
                check("tuser", 64'(m_axis_tuser), 64'd0);
                if (have_prev) begin
                    check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                    check("hold_tdata", m_axis_tdata, prev_data);
                    check("hold_tkeep", 64'(m_axis_tkeep), 64'(prev_keep));
                    check("hold_tlast", 64'(m_axis_tlast), 64'(prev_last));
                end
                if (m_axis_tvalid) begin
                    if (!in_frame) begin
                        model_len = clamp_len(int'(frame_len));
                        build_frame(model_len, model_sent);
                        in_frame = 1'b1;
                        cur_beat = 0;
                        gap_q.push_back(cycle - last_end_cycle - 1);
                    end
                    e_data = '0;
                    for (int i = 0; i < 8; i++)
                        if (8*cur_beat + i < model_len) e_data[8*i +: 8] = exp_frame[8*cur_beat + i];
                    rem    = model_len - 8*cur_beat;
                    e_keep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
                    e_last = (rem <= 8);
                    check("tdata", m_axis_tdata, e_data);
                    check("tkeep", 64'(m_axis_tkeep), 64'(e_keep));
                    check("tlast", 64'(m_axis_tlast), 64'(e_last));
                    if (m_axis_tready) begin
                        for (int i = 0; i < 8; i++)
                            if (8*cur_beat + i < model_len) cap[8*cur_beat + i] = m_axis_tdata[8*i +: 8];
                        cur_beat++;
                        if (e_last) begin
                            in_frame       = 1'b0;
                            model_sent     = model_sent + 1;
                            done_cnt++;
                            last_beats     = cur_beat;
                            last_keep      = m_axis_tkeep;
                            last_end_cycle = cycle;
                            for (int o = 0; o < model_len; o++) last_cap[o] = cap[o];
                        end
                    end
                    have_prev = !m_axis_tready;
                    prev_data = m_axis_tdata;
                    prev_keep = m_axis_tkeep;
                    prev_last = m_axis_tlast;
                end else begin
                    check("tvalid_mid_frame", 64'(in_frame), 64'd0);
                    have_prev = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk_p);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge refclk_p);
            n++;
        end
        #1;
        check("frame_wait_timeout", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge refclk_p);
            n++;
        end
        #1;
        check("idle_wait_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_beat(input int beat, input int budget);
        int n = 0;
        while (!(in_frame && cur_beat == beat) && n < budget) begin
            @(posedge refclk_p);
            n++;
        end
        #1;
        check("beat_wait_timeout", 64'(in_frame && cur_beat == beat), 64'd1);
    endtask

    function automatic logic [31:0] cap_be(input int ofs, input int n);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = {v[23:0], last_cap[ofs+i]};
        return v;
    endfunction

    initial begin
        int base;
        // Reset state
        tick(2);
        @(negedge refclk_p);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_frames_sent", 64'(frames_sent), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge refclk_p);
        #1 reset = 1'b0;

        // Minimum frame, single-frame limit
        frame_len = 11'd60; frame_limit = 32'd1; enable = 1'b1;
        wait_done(1, 300);
        tick(10);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_frames_sent", 64'(frames_sent), 64'd1);
        check("t1_beats", 64'(last_beats), 64'd8);
        check("t1_last_keep", 64'(last_keep), 64'h0F);
        check("t1_ip_total_len", 64'(cap_be(16, 2)), 64'h002E);
        check("t1_udp_len", 64'(cap_be(38, 2)), 64'h001A);
        check("t1_ip_csum", 64'(cap_be(24, 2)), 64'h26BD);
        tick(20);
        check("t1_limit_hold", 64'(done_cnt), 64'd1);

        // Maximum frame; first of these carries seq=1
        enable = 1'b0; tick(3);
        frame_len = 11'd1514; frame_limit = 32'd2; enable = 1'b1;
        wait_done(2, 1000);
        check("t2_beats", 64'(last_beats), 64'd190);
        check("t2_last_keep", 64'(last_keep), 64'h03);
        check("t2_ip_id", 64'(cap_be(18, 2)), 64'h0001);
        check("t2_seq", 64'(cap_be(42, 4)), 64'h0000_0001);
        wait_done(3, 1000);
        wait_idle(50);
        check("t2_frames_sent", 64'(frames_sent), 64'd3);

        // Clamping of out-of-range lengths
        enable = 1'b0; tick(3);
        frame_len = 11'd20; frame_limit = 32'd1; enable = 1'b1;
        wait_done(4, 300);
        check("t3_lo_beats", 64'(last_beats), 64'd8);
        check("t3_lo_keep", 64'(last_keep), 64'h0F);
        check("t3_lo_total_len", 64'(cap_be(16, 2)), 64'h002E);
        enable = 1'b0; tick(3);
        frame_len = 11'd2000; enable = 1'b1;
        wait_done(5, 1000);
        check("t3_hi_beats", 64'(last_beats), 64'd190);
        check("t3_hi_keep", 64'(last_keep), 64'h03);
        check("t3_hi_total_len", 64'(cap_be(16, 2)), 64'h05DC);
        enable = 1'b0;
        wait_idle(50);

        // Random backpressure with random lengths and header fields
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            enable = 1'b0;
            wait_idle(50);
            frame_len = 11'($urandom_range(40, 300));
            dst_mac   = {16'($urandom), 32'($urandom)};
            src_mac   = {16'($urandom), 32'($urandom)};
            src_ip    = $urandom;
            dst_ip    = $urandom;
            src_port  = 16'($urandom);
            dst_port  = 16'($urandom);
            frame_limit = 32'd1;
            base = done_cnt;
            enable = 1'b1;
            wait_done(base + 1, 2000);
        end
        rand_ready = 1'b0;
        enable = 1'b0;
        wait_idle(50);

        // enable drops mid-frame: the frame still completes
        frame_len = 11'd128; frame_limit = 32'd0;
        base = done_cnt;
        enable = 1'b1;
        wait_beat(3, 100);
        enable = 1'b0;
        wait_done(base + 1, 200);
        wait_idle(20);
        tick(10);
        check("t5_one_frame", 64'(done_cnt), 64'(base + 1));
        check("t5_beats", 64'(last_beats), 64'd16);
        check("t5_busy", 64'(busy), 64'd0);

        // Frame limit of 3 with enable held; gaps of GAP_CYCLES plus LOAD
        frame_limit = 32'd3;
        gap_q.delete();
        base = done_cnt;
        enable = 1'b1;
        wait_done(base + 3, 1000);
        wait_idle(20);
        tick(20);
        check("t6_three_frames", 64'(done_cnt), 64'(base + 3));
        check("t6_starts", 64'(gap_q.size()), 64'd3);
        if (gap_q.size() == 3) begin
            check("t6_gap1", 64'(gap_q[1]), 64'(GAP_CYCLES + 1));
            check("t6_gap2", 64'(gap_q[2]), 64'(GAP_CYCLES + 1));
        end
        check("t6_busy", 64'(busy), 64'd0);

        // Reset mid-frame
        enable = 1'b0; tick(3);
        frame_limit = 32'd0; frame_len = 11'd128;
        enable = 1'b1;
        wait_beat(4, 100);
        reset = 1'b1; enable = 1'b0;
        @(posedge refclk_p);
        #1 reset = 1'b0;
        @(negedge refclk_p);
        check("t7_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t7_frames_sent", 64'(frames_sent), 64'd0);
        check("t7_busy", 64'(busy), 64'd0);
        @(posedge refclk_p);
        #1;
        frame_limit = 32'd1;
        base = done_cnt;
        enable = 1'b1;
        wait_done(base + 1, 300);
        check("t7_beats", 64'(last_beats), 64'd16);
        check("t7_first_bytes", 64'({last_cap[0], last_cap[1], last_cap[2], last_cap[3], last_cap[4], last_cap[5]}), 64'(dst_mac));
        check("t7_ip_id", 64'(cap_be(18, 2)), 64'h0000);
        check("t7_seq", 64'(cap_be(42, 4)), 64'h0000_0000);
        enable = 1'b0;
        wait_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
